// File: rtl/sha_pkg.sv
// Shared types and constants for the sha_block work dispatcher.
package sha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SOLVE,
        ST_REP_STATUS,
        ST_REP_NONCE
    } work_state_t;

    localparam logic [31:0] STAT_EXHAUSTED = 32'h0;
    localparam logic [31:0] STAT_FOUND     = 32'h1;
    localparam logic [31:0] STAT_CANCELLED = 32'h2;

    localparam int WORK_WORDS = 24;
    localparam int MID_WORDS  = 8;

endpackage

// File: rtl/sha_work_assembler.sv
// Collects a 24-word work packet into one wide shift register; pulses done on the last word.
module sha_work_assembler
    import sha_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         accept_i,
    input  logic [31:0]  data_i,
    output logic [255:0] mid_state_o,
    output logic [511:0] head_data_o,
    output logic         done_o
);

    logic [WORK_WORDS*32-1:0] sr_q;
    logic [4:0]               cnt_q;

    // Shifting in at the bottom leaves word 0 at the top once all words have arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (accept_i) begin
            sr_q  <= {sr_q[WORK_WORDS*32-33:0], data_i};
            cnt_q <= done_o ? 5'd0 : cnt_q + 5'd1;
        end
    end

    assign done_o      = accept_i && (cnt_q == 5'(WORK_WORDS - 1));
    assign mid_state_o = sr_q[WORK_WORDS*32-1 -: MID_WORDS*32];
    assign head_data_o = sr_q[(WORK_WORDS-MID_WORDS)*32-1:0];

endmodule

// File: rtl/sha_work_manager.sv
// Dispatches work packets to sha_block and returns a (status, nonce) result pair.
module sha_work_manager
    import sha_pkg::*;
#(
    parameter int          LOAD_CYCLES = 2,
    parameter logic [31:0] NONCE_LIMIT = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         cancel,
    output logic [255:0] mid_state,
    output logic [511:0] head_data,
    output logic         load_state,
    output logic         solve_en,
    input  logic         flag,
    input  logic [31:0]  golden_nonce,
    input  logic [31:0]  sha_counter,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [15:0]  found_count
);

    work_state_t state_q, state_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [31:0] status_q, status_d;
    logic [31:0] nonce_q, nonce_d;
    logic [15:0] found_q, found_d;
    logic        pkt_done;

    sha_work_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .accept_i    (in_valid && in_ready),
        .data_i      (in_data),
        .mid_state_o (mid_state),
        .head_data_o (head_data),
        .done_o      (pkt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            status_q   <= '0;
            nonce_q    <= '0;
            found_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            status_q   <= status_d;
            nonce_q    <= nonce_d;
            found_q    <= found_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        status_d   = status_q;
        nonce_d    = nonce_q;
        found_d    = found_q;
        unique case (state_q)
            ST_IDLE: begin
                load_cnt_d = '0;
                if (pkt_done) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_cnt_q == 4'(LOAD_CYCLES - 1)) state_d = ST_SOLVE;
                else load_cnt_d = load_cnt_q + 4'd1;
            end
            ST_SOLVE: begin
                // Priority: flag, then exhaustion, then cancel.
                if (flag) begin
                    status_d = STAT_FOUND;
                    nonce_d  = golden_nonce;
                    if (found_q != 16'hFFFF) found_d = found_q + 16'd1;
                    state_d  = ST_REP_STATUS;
                end else if (sha_counter >= NONCE_LIMIT) begin
                    status_d = STAT_EXHAUSTED;
                    nonce_d  = sha_counter;
                    state_d  = ST_REP_STATUS;
                end else if (cancel) begin
                    status_d = STAT_CANCELLED;
                    nonce_d  = sha_counter;
                    state_d  = ST_REP_STATUS;
                end
            end
            ST_REP_STATUS: if (out_ready) state_d = ST_REP_NONCE;
            ST_REP_NONCE:  if (out_ready) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    assign in_ready    = (state_q == ST_IDLE) && !rst;
    assign load_state  = (state_q == ST_LOAD);
    assign solve_en    = (state_q == ST_SOLVE);
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = (state_q == ST_REP_STATUS) || (state_q == ST_REP_NONCE);
    assign out_data    = (state_q == ST_REP_STATUS) ? status_q :
                         (state_q == ST_REP_NONCE)  ? nonce_q  : 32'h0;
    assign found_count = found_q;

endmodule

// File: tb/tb_sha_work_manager.sv
// Directed bench for sha_work_manager: packet load, FOUND, exhaustion, cancel with backpressure, reset mid-packet.
module tb_sha_work_manager;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         cancel;
    logic [255:0] mid_state;
    logic [511:0] head_data;
    logic         load_state;
    logic         solve_en;
    logic         flag;
    logic [31:0]  golden_nonce;
    logic [31:0]  sha_counter;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic [15:0]  found_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha_work_manager #(.LOAD_CYCLES(2), .NONCE_LIMIT(32'h100)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cancel       (cancel),
        .mid_state    (mid_state),
        .head_data    (head_data),
        .load_state   (load_state),
        .solve_en     (solve_en),
        .flag         (flag),
        .golden_nonce (golden_nonce),
        .sha_counter  (sha_counter),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .found_count  (found_count)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // Inputs change on the falling edge; checks read the state left by the previous rising edge.
    task automatic send_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 32'h0;
    endtask

    // Entered in LOAD cycle 1; leaves in the first SOLVE cycle.
    task automatic check_load(input string tag);
        chk({tag, "_ld1"}, {62'h0, load_state, solve_en}, 64'h2);
        @(negedge clk);
        chk({tag, "_ld2"}, {62'h0, load_state, solve_en}, 64'h2);
        @(negedge clk);
        chk({tag, "_solve"}, {62'h0, load_state, solve_en}, 64'h1);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; cancel = 1'b0; flag = 1'b0;
        golden_nonce = '0; sha_counter = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {59'h0, in_ready, load_state, solve_en, out_valid, busy}, 64'h0);
        chk("rst_out", {16'h0, found_count, out_data}, 64'h0);
        chk("rst_mid", 64'(mid_state != '0), 64'h0);
        chk("rst_head", 64'(head_data != '0), 64'h0);
        rst = 1'b0;
        #1 chk("rdy_after_rst", 64'(in_ready), 64'h1);
        @(negedge clk);

        // Packet load
        send_words(32'h0, 24);
        chk("mid_w0", 64'(mid_state[255:224]), 64'h0);
        chk("mid_w7", 64'(mid_state[31:0]), 64'h7);
        chk("head_w8", 64'(head_data[511:480]), 64'h8);
        chk("head_w23", 64'(head_data[31:0]), 64'h17);
        chk("load_busy", {62'h0, busy, in_ready}, 64'h2);
        check_load("p1");

        // FOUND
        flag = 1'b1; golden_nonce = 32'hDEADBEEF;
        @(negedge clk);
        flag = 1'b0;
        chk("fnd_status", {30'h0, solve_en, out_valid, out_data}, {32'h1, 32'h1});
        chk("fnd_count", 64'(found_count), 64'h1);
        @(negedge clk);
        chk("fnd_nonce", {31'h0, out_valid, out_data}, {32'h1, 32'hDEADBEEF});
        @(negedge clk);
        chk("fnd_idle", {61'h0, out_valid, busy, in_ready}, 64'h1);

        // Exhaustion by counter ramp
        send_words(32'h40, 24);
        check_load("p2");
        sha_counter = 32'hFF;
        @(negedge clk);
        chk("exh_below", 64'(solve_en), 64'h1);
        sha_counter = 32'h100;
        @(negedge clk);
        chk("exh_status", {31'h0, out_valid, out_data}, {32'h1, 32'h0});
        @(negedge clk);
        chk("exh_nonce", {31'h0, out_valid, out_data}, {32'h1, 32'h100});
        sha_counter = 32'h0;
        @(negedge clk);

        // Exhaustion and flag together: FOUND wins
        send_words(32'h80, 24);
        check_load("p3");
        sha_counter = 32'h100; flag = 1'b1; golden_nonce = 32'h1234_5678;
        @(negedge clk);
        flag = 1'b0; sha_counter = 32'h0;
        chk("both_status", {31'h0, out_valid, out_data}, {32'h1, 32'h1});
        chk("both_count", 64'(found_count), 64'h2);
        @(negedge clk);
        chk("both_nonce", 64'(out_data), 64'h1234_5678);
        @(negedge clk);

        // Cancel with backpressure; in_valid must be ignored until IDLE
        send_words(32'hC0, 24);
        check_load("p4");
        sha_counter = 32'h55; cancel = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        cancel = 1'b0; in_valid = 1'b1; in_data = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            chk("cnc_hold", {30'h0, in_ready, out_valid, out_data}, {32'h1, 32'h2});
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("cnc_nonce", {31'h0, out_valid, out_data}, {32'h1, 32'h55});
        chk("cnc_count", 64'(found_count), 64'h2);
        chk("cnc_mid", 64'(mid_state[255:224]), 64'hC0);
        @(negedge clk);
        chk("cnc_idle", {62'h0, busy, in_ready}, 64'h1);
        sha_counter = 32'h0;

        // Reset mid-packet, then a fresh packet
        send_words(32'hA0, 10);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_ctrl", {58'h0, in_ready, load_state, solve_en, out_valid, busy,
                          1'b0}, 64'h0);
        chk("mrst_data", {16'h0, found_count, out_data}, 64'h0);
        chk("mrst_wide", {62'h0, mid_state != '0, head_data != '0}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        send_words(32'h100, 24);
        chk("fresh_mid", 64'(mid_state[255:224]), 64'h100);
        chk("fresh_head_hi", 64'(head_data[511:480]), 64'h108);
        chk("fresh_head_lo", 64'(head_data[31:0]), 64'h117);
        check_load("p5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_work_manager.md
# sha_work_manager

Work dispatcher and result collector on the far side of the `sha_block` solve interface. It accepts a 24-word work packet (midstate plus header data) over a 32-bit valid/ready stream and drives `midState`/`headData`/`loadState`/`solveEn` into `sha_block`. It watches `flag`, `goldenNonce` and `sha_counter`, then returns a two-word result (status, nonce) over a 32-bit valid/ready output stream. The block sits between the host link and `sha_block`.

## Interface
Parameters:
- `LOAD_CYCLES`, default 2: cycles `load_state` is held high before solving (legal range 1–15).
- `NONCE_LIMIT`, default 32'hFFFF_FFFF: `sha_counter` value at or above which the job is exhausted.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 32: work word.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: word accepted when `in_valid & in_ready`.
- `cancel` in 1: abort the current solve.
- `mid_state` out 256: to `sha_block` `midState`.
- `head_data` out 512: to `sha_block` `headData`.
- `load_state` out 1: to `sha_block` `loadState`.
- `solve_en` out 1: to `sha_block` `solveEn`.
- `flag` in 1: from `sha_block`; a golden nonce is found.
- `golden_nonce` in 32: from `sha_block` `goldenNonce`.
- `sha_counter` in 32: from `sha_block` `sha_counter`; current nonce.
- `out_data` out 32: result word.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: result word consumed when `out_valid & out_ready`.
- `busy` out 1: high in every state except IDLE.
- `found_count` out 16: number of FOUND results, saturating at 16'hFFFF.

## Operation
States are IDLE, LOAD, SOLVE, REP_STATUS and REP_NONCE.

- **IDLE**
  - `in_ready` = 1.
  - A 5-bit word counter counts accepted words 0..23.
  - Words 0–7 fill `mid_state`, MSB first: word 0 goes to bits [255:224].
  - Words 8–23 fill `head_data`: word 8 goes to bits [511:480] and word 23 to bits [31:0].
  - Acceptance of word 23 moves the block to LOAD and clears the word counter.
- **LOAD**
  - `load_state` = 1 for exactly `LOAD_CYCLES` cycles, then SOLVE.
  - `mid_state` and `head_data` stay frozen from LOAD until the block returns to IDLE.
- **SOLVE**
  - `solve_en` = 1. Each cycle the inputs are evaluated in priority order: `flag`, then exhaustion, then `cancel`.
  - `flag` = 1: capture `golden_nonce`, set status FOUND (32'h1), increment `found_count` (saturating).
  - `sha_counter >= NONCE_LIMIT`: capture `sha_counter`, set status EXHAUSTED (32'h0).
  - `cancel` = 1: capture `sha_counter`, set status CANCELLED (32'h2).
  - Any of these three events moves the block to REP_STATUS.
- **REP_STATUS**
  - `out_valid` = 1, `out_data` = status.
  - Holds until `out_ready`, then REP_NONCE.
- **REP_NONCE**
  - `out_valid` = 1, `out_data` = captured nonce.
  - Holds until `out_ready`, then IDLE.
- **Outside IDLE**
  - `in_ready` = 0, so no word is accepted.
  - `cancel` is ignored outside SOLVE.
- **Output-stream rules**
  - While `out_valid` = 1, `out_data` does not change until the transfer completes.
  - `out_valid` never drops without a transfer.

## Timing
- **Reset**
  - State is IDLE and the word counter is 0.
  - `mid_state`, `head_data`, `load_state`, `solve_en`, `out_valid`, `out_data` and `found_count` are all 0.
  - `in_ready` = 0 while `rst` = 1, and becomes 1 on the first cycle with `rst` = 0.
- **Reset mid-operation:** applies the same values on the next edge from any state. A partially received packet is discarded and `solve_en` drops immediately.
- **Load latency:** after the edge accepting word 23, `load_state` is high on cycles 1..`LOAD_CYCLES`. `solve_en` is high from cycle `LOAD_CYCLES`+1.
- **Result latency:** a `flag` sampled high at edge N gives `solve_en` = 0 and `out_valid` = 1 after edge N. `out_data` = status in that same cycle.
- **Back-to-back results:** with `out_ready` held high, status and nonce take one cycle each and `in_ready` returns 1 the following cycle. A full job is therefore ≥ 24 + `LOAD_CYCLES` + 1 + 2 cycles.
- **Simultaneous events:** when `flag` and exhaustion are both high, FOUND wins. When `flag` and `cancel` are both high, FOUND wins.
- **Saturation:** `found_count` holds at 16'hFFFF and does not wrap.

## Structure
- Shared package `sha_pkg` holds:
  - the state enum `work_state_t`;
  - status constants `STAT_EXHAUSTED` = 0, `STAT_FOUND` = 1, `STAT_CANCELLED` = 2;
  - `WORK_WORDS` = 24 and `MID_WORDS` = 8.
- One natural sub-module, `sha_work_assembler`: the 24-word shift/load register with its word counter and a `done` pulse.

## Test plan
- **Packet load:** reset, then send words 0x00000000..0x00000017 back-to-back. Required: `mid_state[255:224]` = 0, `head_data[31:0]` = 0x17, `load_state` high for 2 cycles, then `solve_en` = 1.
- **FOUND:** in SOLVE, drive `flag` = 1 and `golden_nonce` = 0xDEADBEEF. Required: the next cycle has `solve_en` = 0 and `out_data` = 0x1, then 0xDEADBEEF; `found_count` = 1.
- **Exhausted with flag:** with `NONCE_LIMIT` = 0x100, ramp `sha_counter` to 0x100 with `flag` = 0. Required: status 0x0, then nonce 0x100. Repeat with `flag` = 1 on the same cycle: required status 0x1.
- **Cancel and backpressure:** cancel in SOLVE at `sha_counter` = 0x55 while `out_ready` = 0 for 5 cycles. Required: `out_valid` and `out_data` = 0x2 held stable, then the nonce 0x55 follows; `in_valid` is ignored until IDLE.
- **Reset mid-packet:** assert `rst` after 10 words. Required: all outputs return to 0. A fresh 24-word packet then loads correctly, with no residue from the aborted one.
